task_sequencer: RTL
===================

Name: task_sequencer

Overview:
- Parametrised successor of the two-engine task trigger.
- Orchestrates one DAC engine and N_CH ADC engines through programmable repetition loops, with four launch modes, per-channel enables, an inter-repetition gap, a watchdog timeout and abort.
- Sits between the host trigger/register interface and the DAC_control / ADC_control instances at the top level.
- Drives their trigger inputs and collects their done pulses.

Parameters:
- N_CH, 2: number of ADC channels/engines.
- REP_W, 16: width of repetition count.
- TO_W, 32: width of watchdog timeout counter.

Ports:
- clk  in  1  system clock (512 kHz)
- rst  in  1  asynchronous, active-low reset
- trigger_task  in  1  start request; sampled high on a clk edge while IDLE
- abort  in  1  synchronous abort, highest priority after reset
- mode  in  2  0=ADC only, 1=DAC only, 2=DAC+ADC concurrent, 3=DAC then ADC
- ch_en  in  N_CH  ADC channel enables
- n_rep  in  REP_W  repetitions; 0 is treated as 1
- t_gap  in  32  idle cycles between repetitions
- timeout  in  TO_W  watchdog cycles per repetition; 0 disables
- done_dac  in  1  DAC engine done pulse
- done_adc  in  N_CH  per-channel ADC done pulses
- trigger_dac  out  1  one-cycle DAC start pulse
- trigger_adc  out  N_CH  one-cycle per-channel ADC start pulses
- busy  out  1  high in every state except IDLE
- done_task  out  1  one-cycle completion pulse
- err_timeout  out  1  sticky watchdog error flag
- rep_cnt  out  REP_W  completed repetitions in the current task

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, all counters 0, sticky done flags cleared.
- Config latch: mode, ch_en, n_rep, t_gap and timeout are latched on the edge that accepts trigger_task. Input changes during a task have no effect.
- Triggers: trigger_task while busy is ignored.
- IDLE:
  - On trigger_task=1: clear rep_cnt, err_timeout and sticky flags; go to LAUNCH.
- LAUNCH (exactly 1 cycle); outputs are registered Moore outputs of this state:
  - mode 0: trigger_adc=ch_en.
  - mode 1: trigger_dac=1.
  - mode 2: both.
  - mode 3: trigger_dac only.
  - Watchdog counter cleared. Next state: WAIT.
  - Latency: first trigger pulse is high in the cycle after the edge that samples trigger_task.
- WAIT:
  - Sticky flags dac_ok and adc_ok[i] set on the corresponding done pulse.
  - Flags for channels not required are preset at LAUNCH: disabled channels, DAC in mode 0, ADC in mode 1.
  - Mode 3: when dac_ok first sets, trigger_adc=ch_en is pulsed the next cycle. ADC done pulses received before that launch are ignored.
  - ch_en=0 in any ADC mode: the ADC part is immediately complete.
  - All flags set: rep_cnt increments. If rep_cnt equals effective n_rep, go to DONE; otherwise go to GAP.
  - Done pulses in IDLE, LAUNCH, GAP or DONE are ignored.
- GAP:
  - Counts t_gap cycles, then goes to LAUNCH.
  - t_gap=0 goes to LAUNCH on the next edge.
- DONE: done_task=1 for one cycle, then IDLE.
- Watchdog:
  - In WAIT, if timeout≠0 and the counter reaches timeout: set err_timeout, pulse done_task, go to IDLE. rep_cnt holds its value.
  - If completion and timeout occur in the same cycle, completion wins.
  - err_timeout clears only on the next accepted trigger_task or on reset.
- Abort:
  - In any non-IDLE state: next state is IDLE. No done_task, no trigger pulses, sticky flags cleared, rep_cnt holds.
  - If abort and trigger_task occur together in IDLE, abort wins (trigger is dropped).
- rep_cnt wraps nowhere: n_rep ≤ 2^REP_W−1 bounds it.

Test Plan:
- Mode 2, ch_en=2'b11, n_rep=1, done_dac at +5, done_adc=01 at +7 and 10 at +9 -> trigger_dac and trigger_adc=11 pulse at cycle +1; done_task pulses once after the last done; rep_cnt=1.
- Mode 3, ch_en=01, done_adc[0] injected before done_dac, then done_dac, then done_adc[0] -> early ADC done is ignored; trigger_adc=01 pulses the cycle after done_dac; done_task pulses only after the second done_adc.
- Mode 1, n_rep=3, t_gap=4 -> three trigger_dac pulses, each ≥4 cycles after the previous done_dac; done_task once; rep_cnt=3.
- Mode 0, ch_en=11, timeout=20, only done_adc[0] arrives -> err_timeout=1 and done_task at cycle 20 of WAIT. The next trigger_task clears err_timeout.
- Abort asserted mid-GAP of rep 2 of 4 -> IDLE next cycle, busy=0, no done_task, rep_cnt=2. trigger_task while busy is ignored.
- rst pulled low mid-WAIT -> all outputs 0 immediately (async). n_rep=0 behaves as 1. ch_en=0 in mode 0 gives done_task 2 cycles after LAUNCH.

Source files
------------

// File: rtl/task_sequencer.sv
// rtl/task_sequencer.sv - DAC/ADC task sequencer with repetition loops, gap, watchdog and abort
module task_sequencer #(
    parameter int N_CH  = 2,
    parameter int REP_W = 16,
    parameter int TO_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_task,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [REP_W-1:0] n_rep,
    input  logic [31:0]      t_gap,
    input  logic [TO_W-1:0]  timeout,
    input  logic             done_dac,
    input  logic [N_CH-1:0]  done_adc,
    output logic             trigger_dac,
    output logic [N_CH-1:0]  trigger_adc,
    output logic             busy,
    output logic             done_task,
    output logic             err_timeout,
    output logic [REP_W-1:0] rep_cnt
);

    localparam logic [1:0] MODE_ADC  = 2'd0;
    localparam logic [1:0] MODE_DAC  = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;
    localparam logic [1:0] MODE_SEQ  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Task configuration, frozen when the task is accepted
    logic [1:0]       mode_q, mode_d;
    logic [N_CH-1:0]  ch_en_q, ch_en_d;
    logic [REP_W-1:0] n_rep_q, n_rep_d;
    logic [31:0]      t_gap_q, t_gap_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;

    // Progress counters
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic [31:0]      gap_q, gap_d;

    // Per-repetition completion tracking; adc_live marks that ADC done pulses count
    logic             dac_ok_q, dac_ok_d;
    logic [N_CH-1:0]  adc_ok_q, adc_ok_d;
    logic             adc_live_q, adc_live_d;

    // Registered output pulses and flags
    logic             trig_dac_q, trig_dac_d;
    logic [N_CH-1:0]  trig_adc_q, trig_adc_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             all_ok;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] n_eff;
    logic [TO_W-1:0]  wd_inc;
    logic [31:0]      gap_inc;

    // Next-state, counter and output-pulse logic
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ch_en_d    = ch_en_q;
        n_rep_d    = n_rep_q;
        t_gap_d    = t_gap_q;
        timeout_d  = timeout_q;
        rep_cnt_d  = rep_cnt_q;
        wd_d       = wd_q;
        gap_d      = gap_q;
        dac_ok_d   = dac_ok_q;
        adc_ok_d   = adc_ok_q;
        adc_live_d = adc_live_q;
        err_d      = err_q;
        trig_dac_d = 1'b0;
        trig_adc_d = '0;
        done_d     = 1'b0;

        all_ok  = dac_ok_q & (&adc_ok_q);
        rep_inc = rep_cnt_q + 1'b1;
        wd_inc  = wd_q + 1'b1;
        gap_inc = gap_q + 32'd1;
        n_eff   = (n_rep_q == '0) ? REP_W'(1) : n_rep_q;

        case (state_q)
            S_IDLE: begin
                if (trigger_task && !abort) begin
                    mode_d     = mode;
                    ch_en_d    = ch_en;
                    n_rep_d    = n_rep;
                    t_gap_d    = t_gap;
                    timeout_d  = timeout;
                    rep_cnt_d  = '0;
                    err_d      = 1'b0;
                    dac_ok_d   = 1'b0;
                    adc_ok_d   = '0;
                    adc_live_d = 1'b0;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Engines the mode does not use, and disabled channels, start out complete
                wd_d       = '0;
                dac_ok_d   = (mode_q == MODE_ADC);
                adc_ok_d   = (mode_q == MODE_DAC) ? '1 : ~ch_en_q;
                adc_live_d = (mode_q != MODE_SEQ);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (all_ok) begin
                    // Completion takes precedence over a watchdog expiry in the same cycle
                    rep_cnt_d = rep_inc;
                    gap_d     = '0;
                    state_d   = (rep_inc == n_eff) ? S_DONE : S_GAP;
                end else if ((timeout_q != '0) && (wd_inc == timeout_q)) begin
                    err_d      = 1'b1;
                    done_d     = 1'b1;
                    dac_ok_d   = 1'b0;
                    adc_ok_d   = '0;
                    adc_live_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    wd_d = wd_inc;
                    if (done_dac) begin
                        dac_ok_d = 1'b1;
                    end
                    if (adc_live_q) begin
                        adc_ok_d = adc_ok_q | done_adc;
                    end
                    // Sequential mode: ADCs start the cycle after the DAC reports done
                    if ((mode_q == MODE_SEQ) && !adc_live_q && done_dac) begin
                        adc_live_d = 1'b1;
                        trig_adc_d = ch_en_q;
                    end
                end
            end
            S_GAP: begin
                if (gap_inc >= t_gap_q) begin
                    state_d = S_LAUNCH;
                end else begin
                    gap_d = gap_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops everything in flight but keeps the repetition count and error flag
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            rep_cnt_d  = rep_cnt_q;
            err_d      = err_q;
            trig_adc_d = '0;
            done_d     = 1'b0;
            dac_ok_d   = 1'b0;
            adc_ok_d   = '0;
            adc_live_d = 1'b0;
        end

        // Launch pulses are registered so they appear during the LAUNCH cycle itself
        if (state_d == S_LAUNCH) begin
            trig_dac_d = (mode_d != MODE_ADC);
            trig_adc_d = ((mode_d == MODE_ADC) || (mode_d == MODE_BOTH)) ? ch_en_d : '0;
        end

        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
    end

    // State, configuration, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            ch_en_q    <= '0;
            n_rep_q    <= '0;
            t_gap_q    <= '0;
            timeout_q  <= '0;
            rep_cnt_q  <= '0;
            wd_q       <= '0;
            gap_q      <= '0;
            dac_ok_q   <= 1'b0;
            adc_ok_q   <= '0;
            adc_live_q <= 1'b0;
            trig_dac_q <= 1'b0;
            trig_adc_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ch_en_q    <= ch_en_d;
            n_rep_q    <= n_rep_d;
            t_gap_q    <= t_gap_d;
            timeout_q  <= timeout_d;
            rep_cnt_q  <= rep_cnt_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
            dac_ok_q   <= dac_ok_d;
            adc_ok_q   <= adc_ok_d;
            adc_live_q <= adc_live_d;
            trig_dac_q <= trig_dac_d;
            trig_adc_q <= trig_adc_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign trigger_dac = trig_dac_q;
    assign trigger_adc = trig_adc_q;
    assign busy        = (state_q != S_IDLE);
    assign done_task   = done_q;
    assign err_timeout = err_q;
    assign rep_cnt     = rep_cnt_q;

endmodule
